// File: rtl/barrel_shift_pkg.sv
// Shared op encodings and per-stage control payload for barrel_shift_pipe.
package barrel_shift_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_ROL = 3'd0;
    localparam op_t OP_ROR = 3'd1;
    localparam op_t OP_SLL = 3'd2;
    localparam op_t OP_SRL = 3'd3;
    localparam op_t OP_SRA = 3'd4;

    // Width-independent part of the stage payload; data/amt are sized by the modules.
    typedef struct packed {
        op_t  op;
        logic sat;
    } stage_ctl_t;

    function automatic logic is_shift(op_t o);
        return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA);
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One registered log-shifter stage: conditional shift/rotate by 2^K with op-dependent fill.
// Data bit WIDTH carries the last bit shifted out so far (used as carry for SLL/SRL/SRA).
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K     = 0,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             adv,
    input  logic             up_vld,
    input  logic [WIDTH:0]   up_data,
    input  logic [SHW-1:0]   up_amt,
    input  stage_ctl_t       up_ctl,
    output logic             dn_vld,
    output logic [WIDTH:0]   dn_data,
    output logic [SHW-1:0]   dn_amt,
    output stage_ctl_t       dn_ctl
);

    localparam int S = 1 << K;

    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] nv;
    logic             ng;

    assign v = up_data[WIDTH-1:0];

    always_comb begin
        nv = v;
        ng = up_data[WIDTH];
        if (up_amt[K]) begin
            case (up_ctl.op)
                OP_ROL: nv = {v[WIDTH-1-S:0], v[WIDTH-1:WIDTH-S]};
                OP_ROR: nv = {v[S-1:0], v[WIDTH-1:S]};
                OP_SLL: begin
                    nv = {v[WIDTH-1-S:0], {S{1'b0}}};
                    ng = v[WIDTH-S];
                end
                OP_SRL: begin
                    nv = {{S{1'b0}}, v[WIDTH-1:S]};
                    ng = v[S-1];
                end
                OP_SRA: begin
                    nv = {{S{v[WIDTH-1]}}, v[WIDTH-1:S]};
                    ng = v[S-1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_vld  <= 1'b0;
            dn_data <= '0;
            dn_amt  <= '0;
            dn_ctl  <= '0;
        end else begin
            if (flush)
                dn_vld <= 1'b0;
            else if (adv)
                dn_vld <= up_vld;
            if (adv) begin
                dn_data <= {ng, nv};
                dn_amt  <= up_amt;
                dn_ctl  <= up_ctl;
            end
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator, one stage per amount bit, valid/ready on both sides.
// Optional BARREL_SHIFT_SAT_EN: shifts by b >= WIDTH saturate instead of wrapping modulo WIDTH.
module barrel_shift_pipe
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    // Index 0 is the unregistered input beat; index SHW is the output register.
    logic [SHW:0]             vld_pipe;
    logic [SHW:0][WIDTH:0]    sdata;
    logic [SHW:0][SHW-1:0]    samt;
    stage_ctl_t [SHW:0]       sctl;

    logic adv;
    logic sat0;

`ifdef BARREL_SHIFT_SAT_EN
    // WIDTH is a power of two, so b >= WIDTH is any bit set above the amount field.
    assign sat0 = is_shift(op) && (|b[WIDTH-1:SHW]);
`else
    logic unused_b_hi;
    assign unused_b_hi = ^b[WIDTH-1:SHW];
    assign sat0 = 1'b0;
`endif

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    assign vld_pipe[0] = in_valid;
    assign sdata[0]    = {1'b0, a};
    assign samt[0]     = b[SHW-1:0];
    assign sctl[0]     = '{op: op, sat: sat0};

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .K     (k),
            .SHW   (SHW)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .adv     (adv),
            .up_vld  (vld_pipe[k]),
            .up_data (sdata[k]),
            .up_amt  (samt[k]),
            .up_ctl  (sctl[k]),
            .dn_vld  (vld_pipe[k+1]),
            .dn_data (sdata[k+1]),
            .dn_amt  (samt[k+1]),
            .dn_ctl  (sctl[k+1])
        );
    end

    logic [WIDTH-1:0] res_raw;
    logic             guard;
    logic             amt_nz;
    stage_ctl_t       lctl;

    assign res_raw   = sdata[SHW][WIDTH-1:0];
    assign guard     = sdata[SHW][WIDTH];
    assign amt_nz    = |samt[SHW];
    assign lctl      = sctl[SHW];
    assign out_valid = vld_pipe[SHW];

    always_comb begin
        result = res_raw;
        carry  = 1'b0;
        if (lctl.sat) begin
            case (lctl.op)
                OP_SLL, OP_SRL: result = '0;
                OP_SRA: begin
                    // Sign fill survives every SRA stage, so res_raw MSB is still a's MSB.
                    result = {WIDTH{res_raw[WIDTH-1]}};
                    carry  = res_raw[WIDTH-1];
                end
                default: ;
            endcase
        end else begin
            case (lctl.op)
                OP_ROL:                 carry = amt_nz & res_raw[0];
                OP_ROR:                 carry = amt_nz & res_raw[WIDTH-1];
                OP_SLL, OP_SRL, OP_SRA: carry = guard;
                default:                carry = 1'b0;
            endcase
        end
        zero = (result == '0);
    end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed self-checking bench for barrel_shift_pipe (WIDTH=16), immediate-assertion style.
module tb_barrel_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry;
    logic        zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    barrel_shift_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single beat with out_ready=1: not valid after 3 edges, valid with the result after 4.
    task automatic shot(input string tag, input logic [2:0] o, input logic [15:0] av,
                        input logic [15:0] bv, input logic [15:0] er, input logic ec,
                        input logic ez);
        op = o; a = av; b = bv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk({tag, " lat3_vld"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, " vld"}, 32'(out_valid), 32'd1);
        chk({tag, " res"}, 32'(result), 32'(er));
        chk({tag, " cy"},  32'(carry),  32'(ec));
        chk({tag, " z"},   32'(zero),   32'(ez));
        tick();
    endtask

    initial begin
        logic [15:0] held;
        int          nacc;
        int          ncons;
        int          stray;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = 3'd0;
        a = '0; b = '0; out_ready = 1'b1;
        #12;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst result",    32'(result),    32'd0);
        chk("rst carry",     32'(carry),     32'd0);
        chk("rst zero",      32'(zero),      32'd1);
        chk("rst in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        shot("rol1_5",    3'd0, 16'h0001, 16'd5,  16'h0020, 1'b0, 1'b0);
        shot("rol1_8",    3'd0, 16'h0001, 16'd8,  16'h0100, 1'b0, 1'b0);
        shot("rol8000_1", 3'd0, 16'h8000, 16'd1,  16'h0001, 1'b1, 1'b0);
        shot("rol_amt0",  3'd0, 16'h5A5A, 16'd0,  16'h5A5A, 1'b0, 1'b0);
        shot("ror1_1",    3'd1, 16'h0001, 16'd1,  16'h8000, 1'b1, 1'b0);
        shot("sra8000_15",3'd4, 16'h8000, 16'd15, 16'hFFFF, 1'b0, 1'b0);
        shot("srl8001_1", 3'd3, 16'h8001, 16'd1,  16'h4000, 1'b1, 1'b0);
        shot("srl18_4",   3'd3, 16'h0018, 16'd4,  16'h0001, 1'b1, 1'b0);
        shot("srl1_1",    3'd3, 16'h0001, 16'd1,  16'h0000, 1'b1, 1'b1);
        shot("sll8001_1", 3'd2, 16'h8001, 16'd1,  16'h0002, 1'b1, 1'b0);
        shot("rsvd5",     3'd5, 16'hABCD, 16'd3,  16'hABCD, 1'b0, 1'b0);
`ifdef BARREL_SHIFT_SAT_EN
        shot("sll_b16",   3'd2, 16'h1234, 16'd16, 16'h0000, 1'b0, 1'b1);
        shot("sra_b20",   3'd4, 16'h8001, 16'd20, 16'hFFFF, 1'b1, 1'b0);
`else
        shot("sll_b16",   3'd2, 16'h1234, 16'd16, 16'h1234, 1'b0, 1'b0);
        shot("sra_b20",   3'd4, 16'h8001, 16'd20, 16'hF800, 1'b0, 1'b0);
`endif

        // 8 back-to-back SLL beats, consumer stalls in cycles 5..9
        nacc = 0; ncons = 0; held = '0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 5 && c <= 9);
            in_valid  = (nacc < 8);
            op = 3'd2; a = 16'h00FF; b = 16'(nacc);
            #1;
            if (c == 6) chk("stall in_ready", 32'(in_ready), 32'd0);
            if (c == 5) held = result;
            if (c == 9) chk("stall hold", 32'(result), 32'(held));
            if (out_valid && out_ready) begin
                chk($sformatf("b2b beat%0d", ncons), 32'(result), 32'(16'h00FF << ncons));
                ncons++;
            end
            if (in_valid && in_ready) nacc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("b2b consumed", 32'(ncons), 32'd8);

        // Async reset with beats in flight
        out_ready = 1'b1;
        op = 3'd0; a = 16'h0001; b = 16'd1; in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst zero",      32'(zero),      32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) stray++;
        end
        chk("midrst stale", 32'(stray), 32'd0);

        // Flush with 4 beats in flight plus a concurrent input beat
        op = 3'd0; a = 16'h0003; b = 16'd1; in_valid = 1'b1;
        repeat (4) tick();
        a = 16'hFFF0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush out_valid", 32'(out_valid), 32'd0);
        a = 16'h0003; b = 16'd2;
        tick();
        in_valid = 1'b0;
        stray = 0;
        tick(); if (out_valid) stray++;
        tick(); if (out_valid) stray++;
        chk("flush drop", 32'(stray), 32'd0);
        tick();
        chk("flush lat4 vld", 32'(out_valid), 32'd1);
        chk("flush lat4 res", 32'(result), 32'h000C);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrel_shift_pipe.md
Name: barrel_shift_pipe

Overview:
Parametrised, pipelined successor to the CPU's combinational 16-bit rotator. Performs rotate-left/right, logical left/right and arithmetic right shifts on a WIDTH-bit operand. The amount is taken from operand b. Uses one log-shifter stage per amount bit, each stage registered. Sits between the register-read and writeback paths for multi-cycle ALU ops, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand/result width; must be a power of two, and 8 or more.
SHW, $clog2(WIDTH), amount bits used from b; derived, not to be overridden.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline clear
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
op  in  3  0=ROL, 1=ROR, 2=SLL, 3=SRL, 4=SRA, 5-7 reserved (pass a unchanged)
a  in  WIDTH  operand
b  in  WIDTH  amount source; low SHW bits used (modulo WIDTH)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  shifted/rotated value
carry  out  1  last bit shifted/rotated out
zero  out  1  result == 0

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0; out_valid=0, result=0, carry=0, zero=1.
- Reset mid-operation discards all in-flight beats. No partial results are emitted after release.
- Pipeline: SHW stages. Stage k applies a shift of 2^k when amt[k]=1. Latency is exactly SHW cycles from accepted input to out_valid (4 for WIDTH=16).
- Global advance: adv = out_ready | ~out_valid. in_ready = adv. Every stage moves when adv=1 and holds when adv=0.
- Throughput is 1 beat/cycle under continuous out_ready. Bubbles propagate as valid=0.
- A beat is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- While out_valid=1 and out_ready=0, result/carry/zero stay stable.
- ROL/ROR: bits wrap around.
- SLL/SRL: vacated bits are filled with 0.
- SRA: vacated bits are filled with a[WIDTH-1].
- An amount of 0 gives result=a and carry=0 for all ops.
- Carry for amt>0:
  - SLL: a[WIDTH-amt]
  - SRL/SRA: a[amt-1]
  - ROL: result[0]
  - ROR: result[WIDTH-1]
- Carry and zero are computed by the final stage. No combinational path runs from in_* to out_*. in_ready depends only on out_valid and out_ready.
- Reserved ops: result=a, carry=0.
- flush: synchronous. All stage valids clear on the next edge and the input beat in that cycle is dropped. flush takes priority over simultaneous accept and consume. Data registers need not clear.
- No internal state exists beyond the per-stage data/op/amt/valid registers.

Optional Feature:
Macro BARREL_SHIFT_SAT_EN.
- Defined: for SLL/SRL/SRA, the full b is compared against WIDTH. When b >= WIDTH:
  - SLL/SRL: result=0, carry=0.
  - SRA: result is all copies of a[WIDTH-1], carry=a[WIDTH-1].
  - Rotates stay modulo WIDTH.
  - A 1-bit saturate flag is added to the pipe and set at stage 0.
- Undefined: all ops use b[SHW-1:0] only (modulo), and the upper b bits are ignored.

Decomposition:
- Package barrel_shift_pkg holds:
  - op encodings: OP_ROL, OP_ROR, OP_SLL, OP_SRL, OP_SRA
  - a typedef for the 3-bit op
  - stage payload struct {data, op, amt, sat, valid}
- One natural sub-module, barrel_shift_stage: one registered conditional 2^k shift with op-dependent fill. It takes parameters WIDTH and K and is instantiated SHW times via generate.
- The top level holds the handshake, the carry/zero computation and the optional saturation logic.

Test Plan:
1. WIDTH=16, ROL, a=0x0001, b=5, out_ready=1 → after 4 cycles result=0x0020, carry=0, zero=0. Then a=0x0001, b=8 → result=0x0100.
2. ROR a=0x0001 b=1 → result=0x8000, carry=1. SRA a=0x8000 b=15 → result=0xFFFF, carry=0. SRL a=0x8001 b=1 → result=0x4000, carry=1.
3. Back-to-back 8 beats of SLL a=0x00FF b=0..7 with out_ready held 0 from cycle 5 to 9:
   - in_ready=0 during the stall.
   - No beat is lost or duplicated.
   - Results come out in order: 0x00FF, 0x01FE, ..., 0x7F80.
4. Assert rst_n=0 asynchronously mid-stream with 3 beats in flight → out_valid=0 and zero=1 immediately. After release no stale results appear.
5. flush with 4 beats in flight plus a concurrent in_valid → next cycle all valids are 0, and the next accepted beat emerges after exactly 4 cycles.
6. SLL a=0x1234 b=16:
   - With BARREL_SHIFT_SAT_EN: result=0x0000, carry=0, zero=1.
   - Without it: result=0x1234, carry=0.
